alu_arbiter: RTL
================

# alu_arbiter

Two-port arbiter and sequencer that shares one `ALU_32BIT` instance between two requesters, e.g. the main execute path and an address/compare unit. Each requester issues an operation (op, A, B) over a valid/ready handshake. The block grants the ALU round-robin and registers the operands in an issue stage. It captures the ALU result and flags into a one-deep response buffer per requester, which returns them over a second valid/ready handshake.

## Interface
- `DATA_W`, 32: operand and result width; must match the ALU.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `reqN_valid` input 1 (N=0,1): requester N presents an operation.
- `reqN_ready` output 1: request accepted when `reqN_valid & reqN_ready`.
- `reqN_op` input 3: ALU opcode.
- `reqN_a`, `reqN_b` input DATA_W: operands.
- `respN_valid` output 1: response buffer N holds a result.
- `respN_ready` input 1: requester N consumes the response.
- `respN_result` output DATA_W: ALU result.
- `respN_c_out`, `respN_v`, `respN_z` output 1: carry, overflow and zero flags.
- `alu_op` output 3; `alu_a`, `alu_b` output DATA_W: drive the shared ALU from the issue stage.
- `alu_result` input DATA_W; `alu_c_out`, `alu_v`, `alu_z` input 1: ALU outputs, combinational from `alu_op/a/b`.

## Operation
- **Opcodes:** 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. The block passes opcodes through unchecked; the ALU defines behaviour for other codes.
- **Issue stage:** registers `s1_valid`, `s1_id`, `s1_op`, `s1_a`, `s1_b`. It drives `alu_*` directly. When `s1_valid=0`, `alu_op/a/b` hold their last values.
- **Eligibility:** requester N is eligible when all of the following hold:
  - `reqN_valid=1`.
  - The issue stage does not hold N, i.e. not (`s1_valid & s1_id==N`).
  - Response buffer N is empty or drains this cycle (`~respN_valid | respN_ready`).
- **Arbitration:** `reqN_ready = eligibleN & grantN`. `reqN_ready` is independent of `reqN_valid` only through the eligibility terms.
  - If one requester is eligible, it wins.
  - If both are eligible, the requester not granted last wins.
  - The last-grant pointer updates only on an accepted handshake.
- **Capture:** when `s1_valid=1`, the block writes `{alu_result, alu_c_out, alu_v, alu_z}` into response buffer `s1_id` and sets `resp[s1_id]_valid`.
- **Response buffer:** `respN_valid` stays set and its data stays stable until `respN_ready`.
- **Simultaneous events:** a drain and a capture on the same buffer in the same cycle leave `respN_valid=1` with the new data.
- **No stalls:** the eligibility rule guarantees the issue stage never stalls and a buffer never overflows.
- **Ordering:** responses per requester return in request order.

## Timing
- **Reset values:**
  - `reqN_ready=0` is derived combinationally, with all valids low after reset.
  - `respN_valid=0`.
  - `respN_result/flags=0`.
  - `s1_valid=0`, `alu_op=000`, `alu_a=alu_b=0`.
  - Last-grant pointer = 1, so port 0 wins the first tie.
- **Latency:** a request accepted in cycle T drives `alu_*` in T+1 and presents `respN_valid=1` in T+2.
- **Throughput:** the ALU accepts one op per cycle overall. A single requester gets at most one op per 2 cycles, so alternating requesters keep the ALU fully busy.
- **Back-pressure:** holding `respN_ready=0` blocks only requester N; the other requester proceeds.
- **Reset mid-operation:** asserting `rst_n` low immediately clears `s1_valid`, both `respN_valid` and the pointer. In-flight operations are discarded with no response.

## Configuration
- `ALU_ARB_RR_EN`:
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, where port 0 always wins a tie and the pointer logic is removed. All other behaviour is unchanged.

## Structure
- Shared package `alu_arb_pkg`:
  - Constants `ALU_OP_AND`, `ALU_OP_OR`, `ALU_OP_ADD`, `ALU_OP_SUB`, `ALU_OP_SLT`, and `ALU_DATA_W=32`.
  - Typedef for the response record `{result, c_out, v, z}`.
- Sub-module `alu_arb_pick`: a two-way eligible-to-grant picker holding the last-grant pointer. It compiles to fixed priority without `ALU_ARB_RR_EN`.
- `ALU_32BIT` is instantiated by the parent, not inside this block. The bench instantiates both.

## Test plan
- **Reset and single op:** after reset, req0 ADD A=12, B=10 → `req0_ready=1` in that cycle, `resp0_valid` 2 cycles later, result=22, `c_out=0`, `z=0`.
- **Tie, round-robin:** req0 AND A=0xAAAAAAAA, B=0x55555555 and req1 SUB A=12, B=12 held together. Port 0 is granted first, port 1 next cycle.
  - resp0: result=0, z=1.
  - resp1: result=0, z=1.
  - Without `ALU_ARB_RR_EN`, with both held continuously, port 0 wins every tie it is eligible for.
- **Back-pressure:** `resp1_ready=0` with resp1 full.
  - `req1_ready` stays 0.
  - req0 OR A=0xAAAAAAAA, B=0x55555555 still completes with result=0xFFFFFFFF.
  - resp1 data stays stable until `resp1_ready` rises.
- **Drain plus new issue:** while `resp0_ready=1` drains buffer 0 in cycle T, req0 SLT A=1, B=2 is accepted in cycle T. The result of 1 appears in T+2 with no bubble on `resp0_valid` beyond the required one.
- **Flags:** ADD A=0xFFFFFFFF, B=0xFFFFFFFF → result=0xFFFFFFFE, `c_out=1`.
- **Reset mid-operation:** pulse `rst_n` low between accept and response → `resp0_valid` and `resp1_valid` stay 0 afterwards and `alu_a=alu_b=0`.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, data width and
// the response record captured from the shared ALU.
package alu_arb_pkg;

   localparam int ALU_DATA_W = 32;

   localparam logic [2:0] ALU_OP_AND = 3'b000;
   localparam logic [2:0] ALU_OP_OR  = 3'b001;
   localparam logic [2:0] ALU_OP_ADD = 3'b010;
   localparam logic [2:0] ALU_OP_SUB = 3'b110;
   localparam logic [2:0] ALU_OP_SLT = 3'b111;

   typedef struct packed {
      logic [ALU_DATA_W-1:0] result;
      logic                  c_out;
      logic                  v;
      logic                  z;
   } alu_resp_t;

   function automatic alu_resp_t alu_pack_resp(
      input logic [ALU_DATA_W-1:0] result,
      input logic                  c_out,
      input logic                  v,
      input logic                  z
   );
      alu_resp_t r;
      r.result = result;
      r.c_out  = c_out;
      r.v      = v;
      r.z      = z;
      return r;
   endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Two-way eligible-to-grant picker. With ALU_ARB_RR_EN defined it keeps a
// last-grant pointer (round robin); otherwise port 0 wins every tie.
import alu_arb_pkg::*;

module alu_arb_pick (
`ifdef ALU_ARB_RR_EN
   input  logic       clk,
   input  logic       rst_n,
`endif
   input  logic [1:0] elig,
   output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
   // last_grant=1 means port 1 was served last, so port 0 wins the next tie
   logic last_grant;

   always_comb begin
      grant = 2'b00;
      if (elig[0] && (!elig[1] || last_grant))
         grant[0] = 1'b1;
      else if (elig[1])
         grant[1] = 1'b1;
   end

   // every grant is taken, since eligibility already includes req_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (|grant)
         last_grant <= grant[1];
   end
`else
   always_comb begin
      grant    = 2'b00;
      grant[0] = elig[0];
      grant[1] = elig[1] & ~elig[0];
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: grant, one issue stage,
// and a one-deep response buffer per port. Macro ALU_ARB_RR_EN selects
// round-robin tie breaking (default: fixed priority to port 0).
import alu_arb_pkg::*;

module alu_arbiter #(
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,

   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic [DATA_W-1:0] resp0_result,
   output logic              resp0_c_out,
   output logic              resp0_v,
   output logic              resp0_z,

   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp1_result,
   output logic              resp1_c_out,
   output logic              resp1_v,
   output logic              resp1_z,

   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_c_out,
   input  logic              alu_v,
   input  logic              alu_z
);

   logic [1:0]        elig;
   logic [1:0]        grant;
   logic [1:0]        acc;
   logic [1:0]        resp_ready;

   logic              s1_valid;
   logic              s1_id;
   logic [2:0]        s1_op;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;

   logic [1:0]        resp_vld;
   alu_resp_t         resp_q [2];
   alu_resp_t         cap;

   assign resp_ready = {resp1_ready, resp0_ready};

   // A port may issue only if its previous op has left the issue stage and
   // its buffer will have room at the next edge; this keeps the pipe stall-free.
   always_comb begin
      elig[0] = req0_valid & ~(s1_valid & ~s1_id) & (~resp_vld[0] | resp0_ready);
      elig[1] = req1_valid & ~(s1_valid &  s1_id) & (~resp_vld[1] | resp1_ready);
   end

   alu_arb_pick u_pick (
`ifdef ALU_ARB_RR_EN
      .clk   (clk),
      .rst_n (rst_n),
`endif
      .elig  (elig),
      .grant (grant)
   );

   assign acc        = elig & grant;
   assign req0_ready = acc[0];
   assign req1_ready = acc[1];

   // ---- issue stage: operands held while idle so the ALU inputs stay quiet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_id    <= 1'b0;
         s1_op    <= ALU_OP_AND;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= |acc;
         if (acc[1]) begin
            s1_id <= 1'b1;
            s1_op <= req1_op;
            s1_a  <= req1_a;
            s1_b  <= req1_b;
         end else if (acc[0]) begin
            s1_id <= 1'b0;
            s1_op <= req0_op;
            s1_a  <= req0_a;
            s1_b  <= req0_b;
         end
      end
   end

   assign alu_op = s1_op;
   assign alu_a  = s1_a;
   assign alu_b  = s1_b;

   assign cap = alu_pack_resp(alu_result, alu_c_out, alu_v, alu_z);

   // ---- response buffers: a capture wins over a same-cycle drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_vld  <= 2'b00;
         resp_q[0] <= '0;
         resp_q[1] <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (s1_valid && (s1_id == 1'(n))) begin
               resp_vld[n] <= 1'b1;
               resp_q[n]   <= cap;
            end else if (resp_ready[n]) begin
               resp_vld[n] <= 1'b0;
            end
         end
      end
   end

   assign resp0_valid  = resp_vld[0];
   assign resp0_result = resp_q[0].result;
   assign resp0_c_out  = resp_q[0].c_out;
   assign resp0_v      = resp_q[0].v;
   assign resp0_z      = resp_q[0].z;

   assign resp1_valid  = resp_vld[1];
   assign resp1_result = resp_q[1].result;
   assign resp1_c_out  = resp_q[1].c_out;
   assign resp1_v      = resp_q[1].v;
   assign resp1_z      = resp_q[1].z;

endmodule
